// File: rtl/timer_dev_pkg.sv
// timer_dev_pkg: register offsets, CTRL bit positions, FSM state and mode codes shared by the timer and bridge.
package timer_dev_pkg;
    localparam logic [1:0] TMR_CTRL    = 2'b00;
    localparam logic [1:0] TMR_PRESET  = 2'b01;
    localparam logic [1:0] TMR_COUNT   = 2'b10;
    localparam int         EN          = 0;
    localparam int         MODE        = 1;
    localparam int         IM          = 3;
    localparam logic [1:0] IDLE        = 2'd0;
    localparam logic [1:0] LOAD        = 2'd1;
    localparam logic [1:0] CNT         = 2'd2;
    localparam logic [1:0] INT         = 2'd3;
    localparam logic [1:0] MODE_RELOAD = 2'b01;
endpackage

// File: rtl/timer_dev.sv
// timer_dev: memory-mapped down-counting timer raising IRQ on HWInt[2].
// Define TIMER_AUTO_RELOAD_EN to make mode 01 auto-reload; otherwise every mode is one-shot.
module timer_dev
    import timer_dev_pkg::*;
#(
    parameter logic [31:0] PRESET_INIT = 32'd0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Addr,
    input  logic        WE,
    input  logic [31:0] Din,
    output logic [31:0] Dout,
    output logic        IRQ
);
`ifdef TIMER_AUTO_RELOAD_EN
    localparam bit RELOAD_EN = 1'b1;
`else
    localparam bit RELOAD_EN = 1'b0;
`endif
    logic [3:0]  ctrl;
    logic [31:0] preset;
    logic [31:0] count;
    logic [1:0]  state;
    logic        irq_flag;
    logic        reload;
    logic        ctrl_wr;
    logic        preset_wr;
    logic        unused_addr;
    assign unused_addr = ^{Addr[31:4], Addr[1:0]};
    assign ctrl_wr     = WE && Addr[3:2] == TMR_CTRL;
    assign preset_wr   = WE && Addr[3:2] == TMR_PRESET;
    assign reload      = RELOAD_EN && ctrl[MODE+:2] == MODE_RELOAD;
    assign IRQ         = ctrl[IM] & irq_flag;
    assign Dout        = Addr[3:2] == TMR_CTRL   ? {28'd0, ctrl} :
                         Addr[3:2] == TMR_PRESET ? preset :
                         Addr[3:2] == TMR_COUNT  ? count : 32'd0;
    // A CTRL write overrides whatever the FSM would have done this cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl     <= '0;
            preset   <= PRESET_INIT;
            count    <= '0;
            state    <= IDLE;
            irq_flag <= 1'b0;
        end else if (ctrl_wr) begin
            ctrl     <= Din[3:0];
            irq_flag <= 1'b0;
            state    <= IDLE;
        end else begin
            if (preset_wr)
                preset <= Din;
            case (state)
                IDLE: if (ctrl[EN]) state <= LOAD;
                LOAD: begin
                    count <= preset;
                    state <= CNT;
                end
                CNT: begin
                    if (!ctrl[EN])
                        state <= IDLE;
                    else if (count > 32'd1)
                        count <= count - 32'd1;
                    else begin
                        count    <= '0;
                        irq_flag <= 1'b1;
                        state    <= INT;
                    end
                end
                default: begin
                    state <= IDLE;
                    if (reload)
                        irq_flag <= 1'b0;
                    else
                        ctrl[EN] <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: table-driven bench for timer_dev with a scoreboard queue of expected Dout/IRQ.
module tb_timer_dev;
  localparam logic [31:0] PI = 32'h0000_0a5a;
`ifdef TIMER_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif
  typedef struct {
    string       name;
    bit          rst;
    bit          we;
    logic [1:0]  a;
    logic [31:0] din;
    logic [31:0] dout;
    bit          irq;
  } vec_t;
  typedef struct {
    string       name;
    logic [31:0] dout;
    bit          irq;
  } exp_t;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        WE = 1'b0;
  logic [31:0] Addr = '0;
  logic [31:0] Din = '0;
  logic [31:0] Dout;
  logic        IRQ;
  vec_t        tbl[$];
  exp_t        sb[$];
  int          applied = 0;
  int          errors = 0;
  always #5 clk = ~clk;
  timer_dev #(.PRESET_INIT(PI)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WE(WE), .Din(Din), .Dout(Dout), .IRQ(IRQ)
  );
  function automatic void add(string n, bit r, bit w, logic [1:0] a, logic [31:0] d,
                              logic [31:0] ed, bit ei);
    vec_t v;
    v.name = n; v.rst = r; v.we = w; v.a = a; v.din = d; v.dout = ed; v.irq = ei;
    tbl.push_back(v);
  endfunction
  function automatic void rd(string n, logic [1:0] a, logic [31:0] ed, bit ei);
    add(n, 1'b0, 1'b0, a, 32'd0, ed, ei);
  endfunction
  function automatic void wr(string n, logic [1:0] a, logic [31:0] d, logic [31:0] ed, bit ei);
    add(n, 1'b0, 1'b1, a, d, ed, ei);
  endfunction
  task automatic chk(string n, int i, logic [31:0] ed, bit ei);
    if (Dout !== ed || IRQ !== ei) begin
      errors++;
      $display("FAIL %s (vec %0d): got Dout=%h IRQ=%b, want Dout=%h IRQ=%b",
               n, i, Dout, IRQ, ed, ei);
    end
  endtask
  initial begin
    exp_t e;
    add("reset", 1'b1, 1'b0, 2'd0, 32'd0, 32'd0, 1'b0);
    rd("rst_ctrl", 2'd0, 32'd0, 1'b0);
    rd("rst_preset", 2'd1, PI, 1'b0);
    rd("rst_count", 2'd2, 32'd0, 1'b0);
    rd("rst_off3", 2'd3, 32'd0, 1'b0);
    wr("os5_preset", 2'd1, 32'd5, 32'd5, 1'b0);
    wr("os5_ctrl", 2'd0, 32'h9, 32'h9, 1'b0);
    rd("os5_c1", 2'd2, 32'd0, 1'b0);
    for (int k = 2; k <= 6; k++) rd("os5_cnt", 2'd2, 32'(7 - k), 1'b0);
    rd("os5_expire", 2'd2, 32'd0, 1'b1);
    rd("os5_hold_ctrl", 2'd0, 32'h8, 1'b1);
    rd("os5_hold2", 2'd0, 32'h8, 1'b1);
    wr("os5_clear", 2'd0, 32'h0, 32'h0, 1'b0);
    wr("ar3_preset", 2'd1, 32'd3, 32'd3, 1'b0);
    wr("ar3_ctrl", 2'd0, 32'hb, 32'hb, 1'b0);
    for (int k = 1; k <= 12; k++) begin
      logic [31:0] c;
      bit          q;
      c = (k == 2 || k == 8) ? 32'd3 : (k == 3 || k == 9) ? 32'd2 :
          (k == 4 || k == 10) ? 32'd1 : 32'd0;
      if (!AR && k > 5) c = 32'd0;
      q = AR ? (k == 5 || k == 11) : (k >= 5);
      rd("ar3_count", 2'd2, c, q);
    end
    rd("ar3_ctrl_rb", 2'd0, AR ? 32'hb : 32'ha, !AR);
    wr("ar3_clear", 2'd0, 32'h0, 32'h0, 1'b0);
    wr("p0_preset", 2'd1, 32'd0, 32'd0, 1'b0);
    wr("p0_ctrl", 2'd0, 32'h9, 32'h9, 1'b0);
    rd("p0_c1", 2'd2, 32'd0, 1'b0);
    rd("p0_c2", 2'd2, 32'd0, 1'b0);
    rd("p0_expire", 2'd2, 32'd0, 1'b1);
    wr("p0_clear", 2'd0, 32'h0, 32'h0, 1'b0);
    wr("p1_preset", 2'd1, 32'd1, 32'd1, 1'b0);
    wr("p1_ctrl", 2'd0, 32'h9, 32'h9, 1'b0);
    rd("p1_c1", 2'd2, 32'd0, 1'b0);
    rd("p1_c2", 2'd2, 32'd1, 1'b0);
    rd("p1_expire", 2'd2, 32'd0, 1'b1);
    wr("p1_clear", 2'd0, 32'h0, 32'h0, 1'b0);
    wr("m100_preset", 2'd1, 32'd100, 32'd100, 1'b0);
    wr("m100_ctrl", 2'd0, 32'h1, 32'h1, 1'b0);
    for (int i = 1; i <= 103; i++)
      rd("m100_count", 2'd2, (i >= 2 && i <= 101) ? 32'(102 - i) : 32'd0, 1'b0);
    rd("m100_en_off", 2'd0, 32'h0, 1'b0);
    wr("m100_im_only", 2'd0, 32'h8, 32'h8, 1'b0);
    rd("m100_im_stays0", 2'd0, 32'h8, 1'b0);
    wr("mid_preset", 2'd1, 32'd60, 32'd60, 1'b0);
    wr("mid_ctrl", 2'd0, 32'h1, 32'h1, 1'b0);
    rd("mid_c1", 2'd2, 32'd0, 1'b0);
    for (int k = 2; k <= 4; k++) rd("mid_cnt", 2'd2, 32'(62 - k), 1'b0);
    wr("mid_preset_wr", 2'd1, 32'd7, 32'd7, 1'b0);
    for (int k = 6; k <= 12; k++) rd("mid_cnt_unaff", 2'd2, 32'(62 - k), 1'b0);
    add("mid_reset", 1'b1, 1'b1, 2'd0, 32'hf, 32'h0, 1'b0);
    rd("mid_count0", 2'd2, 32'd0, 1'b0);
    rd("mid_preset_init", 2'd1, PI, 1'b0);
    for (int k = 0; k < 3; k++) rd("mid_frozen", 2'd2, 32'd0, 1'b0);
    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      reset = tbl[i].rst;
      WE    = tbl[i].we;
      Din   = tbl[i].din;
      Addr  = 32'h7f00_0003 | {28'd0, tbl[i].a, 2'b00};
      e.name = tbl[i].name; e.dout = tbl[i].dout; e.irq = tbl[i].irq;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      applied++;
      chk(e.name, i, e.dout, e.irq);
      if (i == 0) begin
        Addr = 32'h7f00_0003;
        #1;
        chk("reset_state_ctrl", i, 32'd0, 1'b0);
      end
    end
    if (applied != tbl.size() || sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: applied=%0d of %0d, %0d expectations left",
               applied, tbl.size(), sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", applied, errors);
    $finish;
  end
endmodule
